// File: rtl/pipe_reg_reader_pkg.sv
// Shared definitions for the MEM/WB pipeline-register reader.
// Holds the FSM state encoding, the byte width, the snapshot word
// indices and the bytes-per-word helpers used by pipe_reg_reader.
package pipe_reg_reader_pkg;

  // Width of one streamed byte.
  localparam int BYTE_WIDTH = 8;

  // Default pipeline-register word width and derived bytes per word.
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / BYTE_WIDTH;

  // Snapshot word indices, in streaming order.
  localparam int CTRL      = 0;
  localparam int DATA      = 1;
  localparam int ALU       = 2;
  localparam int RD        = 3;
  localparam int NUM_WORDS = 4;

  // Streamer FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of bytes in a word of the given width.
  function automatic int bytes_per_word(input int data_width);
    return data_width / BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/pipe_reg_reader.sv
// pipe_reg_reader
// Snapshots the MEM/WB pipeline register (ctrl, data, alu, rd) on a start
// request and streams it out one byte at a time to a ready/valid byte sink
// (typically a UART TX). Words go out in ctrl, data, alu, rd order, each
// word little-endian.
//
// Ports
//   clk         : clock, rising edge
//   i_rst       : synchronous active-high reset
//   i_start     : take a snapshot and start streaming (honoured in IDLE only)
//   i_ctrl      : MEM/WB control word
//   i_data      : MEM/WB data word
//   i_alu       : MEM/WB ALU result word
//   i_rd        : MEM/WB destination register word
//   i_tx_ready  : sink can accept a byte
//   o_tx_data   : byte presented to the sink
//   o_tx_valid  : o_tx_data is valid
//   o_busy      : a snapshot is being streamed (SEND and DONE)
//   o_done      : one-cycle pulse after the last byte is accepted
module pipe_reg_reader
  import pipe_reg_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NWORDS     = 4
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_ctrl,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] i_alu,
  input  logic [DATA_WIDTH-1:0] i_rd,
  input  logic                  i_tx_ready,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WCW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NWORDS - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] snap [NUM_WORDS];
  logic [BCW-1:0]        byte_cnt;
  logic [WCW-1:0]        word_cnt;

  logic [BCW-1:0]        nxt_byte;
  logic [WCW-1:0]        nxt_word;
  logic                  last_xfer;
  logic [7:0]            nxt_tx_data;

  // Position and value of the byte that follows the one currently presented.
  // The byte register is loaded one transfer ahead so o_tx_data stays a
  // registered output without adding a cycle of latency.
  always_comb begin
    nxt_byte  = '0;
    nxt_word  = word_cnt;
    last_xfer = 1'b0;
    if (byte_cnt == LAST_BYTE) begin
      nxt_byte  = '0;
      nxt_word  = word_cnt + 1'b1;
      last_xfer = (word_cnt == LAST_WORD);
    end else begin
      nxt_byte  = byte_cnt + 1'b1;
      nxt_word  = word_cnt;
      last_xfer = 1'b0;
    end
    nxt_tx_data = snap[nxt_word][int'(nxt_byte) * BYTE_WIDTH +: BYTE_WIDTH];
  end

  // Streamer FSM with snapshot capture, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        snap[i] <= '0;
      end
      o_tx_data  <= 8'h00;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            snap[CTRL] <= i_ctrl;
            snap[DATA] <= i_data;
            snap[ALU]  <= i_alu;
            snap[RD]   <= i_rd;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            // First byte comes straight from the input so it is valid
            // in the cycle right after the start edge.
            o_tx_data  <= i_ctrl[BYTE_WIDTH-1:0];
            o_tx_valid <= 1'b1;
            o_busy     <= 1'b1;
            o_done     <= 1'b0;
            state      <= SEND;
          end else begin
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            state      <= IDLE;
          end
        end
        SEND: begin
          if (i_tx_ready) begin
            if (last_xfer) begin
              o_tx_data  <= 8'h00;
              o_tx_valid <= 1'b0;
              o_done     <= 1'b1;
              state      <= DONE;
            end else begin
              byte_cnt   <= nxt_byte;
              word_cnt   <= nxt_word;
              o_tx_data  <= nxt_tx_data;
              state      <= SEND;
            end
          end else begin
            // Sink stalled: hold the presented byte.
            state <= SEND;
          end
        end
        DONE: begin
          o_done     <= 1'b0;
          o_busy     <= 1'b0;
          o_tx_valid <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          o_tx_data  <= 8'h00;
          o_tx_valid <= 1'b0;
          o_busy     <= 1'b0;
          o_done     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_reg_reader.sv
module tb_pipe_reg_reader;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [31:0] i_ctrl, i_data, i_alu, i_rd;
  logic        i_tx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid, o_busy, o_done;

  logic        s_start;
  logic [15:0] s_ctrl, s_data, s_alu, s_rd;
  logic        s_ready;
  logic [7:0]  s_tx_data;
  logic        s_tx_valid, s_busy, s_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_reg_reader #(.DATA_WIDTH(32), .NWORDS(4)) dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start),
    .i_ctrl(i_ctrl), .i_data(i_data), .i_alu(i_alu), .i_rd(i_rd),
    .i_tx_ready(i_tx_ready), .o_tx_data(o_tx_data),
    .o_tx_valid(o_tx_valid), .o_busy(o_busy), .o_done(o_done)
  );

  pipe_reg_reader #(.DATA_WIDTH(16), .NWORDS(4)) dut16 (
    .clk(clk), .i_rst(i_rst), .i_start(s_start),
    .i_ctrl(s_ctrl), .i_data(s_data), .i_alu(s_alu), .i_rd(s_rd),
    .i_tx_ready(s_ready), .o_tx_data(s_tx_data),
    .o_tx_valid(s_tx_valid), .o_busy(s_busy), .o_done(s_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: bytes of each word in word order, little-endian.
  function automatic void build_bytes(input logic [31:0] w0, w1, w2, w3,
                                      input int bpw, output logic [7:0] q[$]);
    logic [31:0] words[4];
    words = '{w0, w1, w2, w3};
    q = {};
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < bpw; b++)
        q.push_back(8'((words[w] >> (8 * b)) & 32'hFF));
  endfunction

  // mode: 0 = ready always 1, 1 = ready alternates 1,0, 2 = random ready.
  task automatic run_stream(input logic [31:0] c, d, a, r, input int mode,
                            input bit clobber, input bit restart_mid,
                            input int abort_after);
    logic [7:0] exp[$];
    logic [7:0] prev;
    bit         rdy, prev_rdy;
    int         idx, cycles;
    build_bytes(c, d, a, r, 4, exp);
    i_ctrl = c; i_data = d; i_alu = a; i_rd = r;
    i_start = 1'b1;
    i_tx_ready = 1'b0;
    tick();
    i_start = 1'b0;
    if (clobber) begin
      i_ctrl = 32'hFFFF_FFFF; i_data = 32'hFFFF_FFFF;
      i_alu  = 32'hFFFF_FFFF; i_rd   = 32'hFFFF_FFFF;
    end
    idx = 0; cycles = 0; prev_rdy = 1'b1; prev = 8'h00;
    while (idx < exp.size() && cycles < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cycles % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_tx_ready = rdy;
      i_start = (restart_mid && idx == 6);
      chk("valid", {31'd0, o_tx_valid}, 32'd1);
      chk("busy", {31'd0, o_busy}, 32'd1);
      chk("byte", {24'd0, o_tx_data}, {24'd0, exp[idx]});
      if (!prev_rdy) chk("stall_stable", {24'd0, o_tx_data}, {24'd0, prev});
      prev = o_tx_data;
      prev_rdy = rdy;
      if (mode == 2 && $urandom_range(0, 3) == 0) begin
        i_ctrl = $urandom; i_data = $urandom; i_alu = $urandom; i_rd = $urandom;
      end
      tick();
      cycles++;
      if (rdy) idx++;
      if (abort_after > 0 && idx == abort_after) begin
        i_start = 1'b0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("abort_valid", {31'd0, o_tx_valid}, 32'd0);
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_done", {31'd0, o_done}, 32'd0);
        chk("abort_data", {24'd0, o_tx_data}, 32'd0);
        return;
      end
    end
    i_start = 1'b0;
    i_tx_ready = 1'($urandom_range(0, 1));
    chk("no_timeout", {31'd0, (cycles < 200)}, 32'd1);
    if (mode == 0) chk("cycles_back2back", cycles, exp.size());
    if (mode == 1) chk("cycles_alternate", cycles, 2 * exp.size() - 1);
    chk("done_pulse", {31'd0, o_done}, 32'd1);
    chk("done_valid", {31'd0, o_tx_valid}, 32'd0);
    chk("done_busy", {31'd0, o_busy}, 32'd1);
    tick();
    chk("after_done", {31'd0, o_done}, 32'd0);
    chk("after_busy", {31'd0, o_busy}, 32'd0);
    chk("after_valid", {31'd0, o_tx_valid}, 32'd0);
    tick();
    chk("idle_busy", {31'd0, o_busy}, 32'd0);
    chk("idle_done", {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    logic [7:0] exp16[$];
    int         cyc;
    i_rst = 1'b1; i_start = 1'b0; i_tx_ready = 1'b0;
    i_ctrl = 32'd0; i_data = 32'd0; i_alu = 32'd0; i_rd = 32'd0;
    s_start = 1'b0; s_ready = 1'b0;
    s_ctrl = 16'd0; s_data = 16'd0; s_alu = 16'd0; s_rd = 16'd0;
    tick(); tick();
    i_rst = 1'b0;
    chk("rst_valid", {31'd0, o_tx_valid}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_data", {24'd0, o_tx_data}, 32'd0);
    chk("rst16_busy", {31'd0, s_busy}, 32'd0);
    tick();

    // Directed: back-to-back, alternating ready, clobbered inputs, second start.
    run_stream(32'h1122_3344, 32'hAABB_CCDD, 32'h0102_0304, 32'h0000_001F, 0, 1'b0, 1'b0, 0);
    run_stream(32'h1122_3344, 32'hAABB_CCDD, 32'h0102_0304, 32'h0000_001F, 1, 1'b0, 1'b0, 0);
    run_stream(32'h1122_3344, 32'hAABB_CCDD, 32'h0102_0304, 32'h0000_001F, 0, 1'b1, 1'b0, 0);
    run_stream(32'h1122_3344, 32'hAABB_CCDD, 32'h0102_0304, 32'h0000_001F, 0, 1'b0, 1'b1, 0);

    // Reset after 5 transfers, then restart from the first byte.
    run_stream(32'h1122_3344, 32'hAABB_CCDD, 32'h0102_0304, 32'h0000_001F, 0, 1'b0, 1'b0, 5);
    run_stream(32'h1122_3344, 32'hAABB_CCDD, 32'h0102_0304, 32'h0000_001F, 0, 1'b0, 1'b0, 0);

    // Reset wins over a simultaneous start.
    i_rst = 1'b1; i_start = 1'b1;
    tick();
    i_rst = 1'b0; i_start = 1'b0;
    chk("prio_busy", {31'd0, o_busy}, 32'd0);
    chk("prio_valid", {31'd0, o_tx_valid}, 32'd0);
    tick();
    chk("prio_still_idle", {31'd0, o_busy}, 32'd0);

    // Randomized words, ready pattern and mid-stream input churn.
    for (int it = 0; it < 8; it++) begin
      run_stream($urandom, $urandom, $urandom, $urandom, 2, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 0);
    end

    // 16-bit word instance.
    s_ctrl = 16'h1234; s_data = 16'h5678; s_alu = 16'h9ABC; s_rd = 16'h0003;
    build_bytes({16'd0, s_ctrl}, {16'd0, s_data}, {16'd0, s_alu}, {16'd0, s_rd}, 2, exp16);
    s_start = 1'b1; s_ready = 1'b1;
    tick();
    s_start = 1'b0;
    cyc = 0;
    foreach (exp16[k]) begin
      chk("w16_valid", {31'd0, s_tx_valid}, 32'd1);
      chk("w16_byte", {24'd0, s_tx_data}, {24'd0, exp16[k]});
      tick();
      cyc++;
    end
    chk("w16_count", cyc, 8);
    chk("w16_done", {31'd0, s_done}, 32'd1);
    chk("w16_done_valid", {31'd0, s_tx_valid}, 32'd0);
    tick();
    chk("w16_after_done", {31'd0, s_done}, 32'd0);
    chk("w16_after_busy", {31'd0, s_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
